// File: rtl/wash_pkg.sv
// Shared encodings and default timings for the wash sequencer and its controller.
// Purely declarative; no clocked logic, no flow control.
package wash_pkg;

  typedef enum logic [2:0] {
    shutDownST = 3'd0,
    beginST    = 3'd1,
    setST      = 3'd2,
    runST      = 3'd3,
    errorST    = 3'd4,
    pauseST    = 3'd5,
    finishST   = 3'd6
  } ctrlState_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WASH  = 3'd1,
    RINSE = 3'd2,
    SPIN  = 3'd3,
    DONE  = 3'd4
  } phase_t;

  localparam int DEF_INIT_SEC   = 5;
  localparam int DEF_FINISH_SEC = 5;
  localparam int DEF_FILL_SEC   = 3;
  localparam int DEF_WASH_SEC   = 12;
  localparam int DEF_RINSE_SEC  = 8;
  localparam int DEF_SPIN_SEC   = 6;

  // First selected phase strictly after cur, or DONE when the program is exhausted.
  function automatic phase_t nextPhaseOf(phase_t cur, logic [2:0] prog);
    if (cur < WASH && prog[0]) return WASH;
    if (cur < RINSE && prog[1]) return RINSE;
    if (cur < SPIN && prog[2]) return SPIN;
    return DONE;
  endfunction

endpackage

// File: rtl/wash_sequencer_sec_countdown.sv
// Saturating seconds down-counter with load priority over tick; result visible one cp after the edge.
// No backpressure: ticks arriving at zero are dropped.
module sec_countdown #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         cp,
  input  logic         resetBtn,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge cp or negedge resetBtn) begin
    if (!resetBtn) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= loadVal;
    end else if (tick && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/wash_sequencer.sv
// Wash/rinse/spin phase sequencer with self-test and finish-hold timers; all outputs registered, 1-cp latency.
// No backpressure; optional finish buzzer output when WASH_BUZZER_EN is defined.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int INIT_SEC   = DEF_INIT_SEC,
  parameter int FINISH_SEC = DEF_FINISH_SEC,
  parameter int FILL_SEC   = DEF_FILL_SEC,
  parameter int WASH_SEC   = DEF_WASH_SEC,
  parameter int RINSE_SEC  = DEF_RINSE_SEC,
  parameter int SPIN_SEC   = DEF_SPIN_SEC
) (
  input  logic       cp,
  input  logic       resetBtn,
  input  logic       tick1s,
  input  logic [2:0] state,
  input  logic [2:0] modeSel,
  output logic [2:0] initTime,
  output logic [2:0] finishTime,
  output logic       hadFinish,
  output logic [2:0] phase,
  output logic [7:0] remainTime,
  output logic       inletOn,
  output logic       drainOn,
  output logic       motorOn
`ifdef WASH_BUZZER_EN
  ,
  output logic       buzzer
`endif
);

  localparam logic [7:0] WASH_DUR       = 8'(WASH_SEC);
  localparam logic [7:0] RINSE_DUR      = 8'(RINSE_SEC);
  localparam logic [7:0] SPIN_DUR       = 8'(SPIN_SEC);
  localparam logic [7:0] WASH_FILL_END  = 8'(WASH_SEC - FILL_SEC);
  localparam logic [7:0] RINSE_FILL_END = 8'(RINSE_SEC - FILL_SEC);

  function automatic logic [7:0] durOf(phase_t p);
    case (p)
      WASH:    return WASH_DUR;
      RINSE:   return RINSE_DUR;
      SPIN:    return SPIN_DUR;
      default: return 8'd0;
    endcase
  endfunction

  phase_t     phaseQ, phaseNext;
  logic [2:0] prog;
  logic       initZero, finishZero, remainZero;
  logic       remLoad, remTick;
  logic [7:0] remLoadVal, remNext;
  logic       inletNext, drainNext, motorNext;

  sec_countdown #(.W(3), .RST_VAL(3'(INIT_SEC))) u_initCnt (
    .cp(cp), .resetBtn(resetBtn),
    .load(state != beginST), .loadVal(3'(INIT_SEC)),
    .tick(tick1s && !initZero),
    .count(initTime), .zero(initZero)
  );

  sec_countdown #(.W(3), .RST_VAL(3'(FINISH_SEC))) u_finishCnt (
    .cp(cp), .resetBtn(resetBtn),
    .load(state != finishST), .loadVal(3'(FINISH_SEC)),
    .tick(tick1s && !finishZero),
    .count(finishTime), .zero(finishZero)
  );

  sec_countdown #(.W(8), .RST_VAL(8'd0)) u_remainCnt (
    .cp(cp), .resetBtn(resetBtn),
    .load(remLoad), .loadVal(remLoadVal),
    .tick(remTick),
    .count(remainTime), .zero(remainZero)
  );

  always_ff @(posedge cp or negedge resetBtn) begin
    if (!resetBtn) begin
      phaseQ    <= IDLE;
      prog      <= 3'b111;
      hadFinish <= 1'b0;
      inletOn   <= 1'b0;
      drainOn   <= 1'b0;
      motorOn   <= 1'b0;
    end else begin
      phaseQ    <= phaseNext;
      hadFinish <= (phaseNext == DONE);
      inletOn   <= inletNext;
      drainOn   <= drainNext;
      motorOn   <= motorNext;
      if (state == setST) begin
        prog <= (modeSel == 3'b000) ? 3'b111 : modeSel;
      end
    end
  end

  // Begin, finish, pause, error and the unused code 7 all freeze the sequence.
  always_comb begin
    phaseNext  = phaseQ;
    remLoad    = 1'b0;
    remLoadVal = 8'd0;
    remTick    = 1'b0;
    inletNext  = 1'b0;
    drainNext  = 1'b0;
    motorNext  = 1'b0;

    case (state)
      shutDownST, setST: begin
        phaseNext = IDLE;
        remLoad   = 1'b1;
      end
      runST: begin
        if (phaseQ == IDLE) begin
          phaseNext  = nextPhaseOf(IDLE, prog);
          remLoad    = 1'b1;
          remLoadVal = durOf(phaseNext);
        end else if (phaseQ != DONE && tick1s && !remainZero) begin
          if (remainTime == 8'd1) begin
            phaseNext  = nextPhaseOf(phaseQ, prog);
            remLoad    = 1'b1;
            remLoadVal = durOf(phaseNext);
          end else begin
            remTick = 1'b1;
          end
        end
      end
      default: ;
    endcase

    remNext = remLoad ? remLoadVal : (remTick ? remainTime - 8'd1 : remainTime);

    // Actuators follow the post-edge phase/time so they stay aligned with remainTime.
    if (state == runST) begin
      case (phaseNext)
        WASH: begin
          inletNext = (remNext > WASH_FILL_END);
          motorNext = !(remNext > WASH_FILL_END);
        end
        RINSE: begin
          inletNext = (remNext > RINSE_FILL_END);
          motorNext = !(remNext > RINSE_FILL_END);
        end
        SPIN: begin
          drainNext = 1'b1;
          motorNext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign phase = phaseQ;

`ifdef WASH_BUZZER_EN
  always_ff @(posedge cp or negedge resetBtn) begin
    if (!resetBtn) begin
      buzzer <= 1'b0;
    end else if (state != finishST) begin
      buzzer <= 1'b0;
    end else if (tick1s) begin
      buzzer <= ~buzzer;
    end
  end
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed scoreboard bench for wash_sequencer: stimulus queues expected field values, a negedge monitor checks them.
module tb_wash_sequencer;

  localparam logic [2:0] SD = 3'd0, BG = 3'd1, SE = 3'd2, RU = 3'd3, ER = 3'd4, PA = 3'd5, FI = 3'd6;
  localparam logic [7:0] ACT_OFF = 8'b000, ACT_MOTOR = 8'b001, ACT_SPIN = 8'b011, ACT_INLET = 8'b100;

  typedef enum int {K_INIT, K_FINISH, K_PHASE, K_REM, K_ACT, K_HAD, K_BUZ} kind_t;
  typedef struct {
    int         cyc;
    kind_t      kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       cp = 1'b0;
  logic       resetBtn;
  logic       tick1s;
  logic [2:0] state;
  logic [2:0] modeSel;
  logic [2:0] initTime, finishTime, phase;
  logic       hadFinish, inletOn, drainOn, motorOn;
  logic [7:0] remainTime;
`ifdef WASH_BUZZER_EN
  logic       buzzer;
`endif

  int   cyc = 0;
  int   nPass = 0;
  int   nTotal = 0;
  exp_t sb[$];
  exp_t e;

  wash_sequencer dut (
    .cp(cp), .resetBtn(resetBtn), .tick1s(tick1s), .state(state), .modeSel(modeSel),
    .initTime(initTime), .finishTime(finishTime), .hadFinish(hadFinish), .phase(phase),
    .remainTime(remainTime), .inletOn(inletOn), .drainOn(drainOn), .motorOn(motorOn)
`ifdef WASH_BUZZER_EN
    , .buzzer(buzzer)
`endif
  );

  always #5 cp = ~cp;
  always @(posedge cp) cyc <= cyc + 1;

  function automatic logic [7:0] sample(kind_t k);
    case (k)
      K_INIT:   return {5'd0, initTime};
      K_FINISH: return {5'd0, finishTime};
      K_PHASE:  return {5'd0, phase};
      K_REM:    return remainTime;
      K_ACT:    return {5'd0, inletOn, drainOn, motorOn};
      K_HAD:    return {7'd0, hadFinish};
`ifdef WASH_BUZZER_EN
      K_BUZ:    return {7'd0, buzzer};
`endif
      default:  return 8'hxx;
    endcase
  endfunction

  always @(negedge cp) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      nTotal++;
      if (sample(e.kind) === e.val) nPass++;
      else $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, sample(e.kind), e.val);
    end
  end

  // Expectation for the outputs after the next active edge.
  task automatic want(input kind_t k, input logic [7:0] v, input string n);
    sb.push_back('{cyc + 1, k, v, n});
  endtask

  // Expectation for the outputs at the coming negedge with no cp edge in between.
  task automatic wantNow(input kind_t k, input logic [7:0] v, input string n);
    sb.push_back('{cyc, k, v, n});
  endtask

  task automatic step(input logic t, input logic [2:0] s);
    @(negedge cp);
    tick1s = t;
    state  = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks still queued", sb.size());
    $display("%0d/%0d checks passed", nPass, nTotal + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    resetBtn = 1'b0;
    tick1s   = 1'b0;
    state    = SD;
    modeSel  = 3'b000;

    @(posedge cp); #2;
    wantNow(K_INIT, 8'd5, "rst_initTime");
    wantNow(K_FINISH, 8'd5, "rst_finishTime");
    wantNow(K_PHASE, 8'd0, "rst_phase");
    wantNow(K_REM, 8'd0, "rst_remainTime");
    wantNow(K_HAD, 8'd0, "rst_hadFinish");
    wantNow(K_ACT, ACT_OFF, "rst_actuators");
    @(negedge cp); #1 resetBtn = 1'b1;

    // Self-test countdown saturates at zero, reloads outside begin.
    step(1'b0, BG); want(K_INIT, 8'd5, "init_hold_no_tick");
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, BG); want(K_INIT, (i <= 5) ? 8'(5 - i) : 8'd0, "init_tick");
    end
    step(1'b0, SD); want(K_INIT, 8'd5, "init_reload"); want(K_FINISH, 8'd5, "finish_idle");

    // Wash + spin program; modeSel changes after set must not matter.
    modeSel = 3'b101;
    step(1'b0, SE); want(K_PHASE, 8'd0, "set_phase_idle"); want(K_REM, 8'd0, "set_remain");
    step(1'b0, RU); modeSel = 3'b010;
    want(K_PHASE, 8'd1, "ws_start_phase"); want(K_REM, 8'd12, "ws_start_remain"); want(K_ACT, ACT_INLET, "ws_start_act");
    for (int k = 1; k <= 18; k++) begin
      step(1'b1, RU);
      if (k < 12) begin
        want(K_PHASE, 8'd1, "ws_wash_phase");
        want(K_REM, 8'(12 - k), "ws_wash_remain");
        want(K_ACT, (12 - k > 9) ? ACT_INLET : ACT_MOTOR, "ws_wash_act");
      end else if (k < 18) begin
        want(K_PHASE, 8'd3, "ws_spin_phase");
        want(K_REM, 8'(18 - k), "ws_spin_remain");
        want(K_ACT, ACT_SPIN, "ws_spin_act");
      end else begin
        want(K_PHASE, 8'd4, "ws_done_phase");
        want(K_REM, 8'd0, "ws_done_remain");
        want(K_ACT, ACT_OFF, "ws_done_act");
      end
      want(K_HAD, (k == 18) ? 8'd1 : 8'd0, "ws_hadFinish");
    end
    step(1'b1, RU); want(K_PHASE, 8'd4, "done_holds"); want(K_HAD, 8'd1, "done_had_holds");
    step(1'b0, FI); want(K_HAD, 8'd1, "finish_had_holds"); want(K_FINISH, 8'd5, "finish_start");
`ifdef WASH_BUZZER_EN
    want(K_BUZ, 8'd0, "buzzer_start");
`endif
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, FI); want(K_FINISH, 8'(5 - k), "finish_tick");
`ifdef WASH_BUZZER_EN
      want(K_BUZ, 8'(k % 2), "buzzer_toggle");
`endif
    end
    step(1'b0, SD); want(K_HAD, 8'd0, "sd_had_clear"); want(K_PHASE, 8'd0, "sd_phase"); want(K_FINISH, 8'd5, "finish_reload");
`ifdef WASH_BUZZER_EN
    want(K_BUZ, 8'd0, "buzzer_off");
`endif

    // Pause and error freeze the countdown and drop actuators; run resumes.
    modeSel = 3'b001;
    step(1'b0, SE);
    step(1'b0, RU); want(K_REM, 8'd12, "pr_start");
    for (int k = 1; k <= 5; k++) step(1'b1, RU);
    want(K_REM, 8'd7, "pr_before_pause"); want(K_ACT, ACT_MOTOR, "pr_before_act");
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, PA);
      want(K_REM, 8'd7, "pause_remain"); want(K_ACT, ACT_OFF, "pause_act"); want(K_PHASE, 8'd1, "pause_phase");
    end
    step(1'b0, RU); want(K_REM, 8'd7, "resume_remain"); want(K_ACT, ACT_MOTOR, "resume_act");
    step(1'b1, RU); want(K_REM, 8'd6, "resume_tick");
    step(1'b1, 3'd7); want(K_REM, 8'd6, "code7_freeze"); want(K_ACT, ACT_OFF, "code7_act");
    step(1'b1, ER); want(K_REM, 8'd6, "error_freeze");
    step(1'b0, SD); want(K_PHASE, 8'd0, "sd_phase2"); want(K_REM, 8'd0, "sd_remain2");

    // modeSel=0 runs the full program.
    modeSel = 3'b000;
    step(1'b0, SE);
    step(1'b0, RU); want(K_PHASE, 8'd1, "full_start");
    for (int k = 1; k <= 26; k++) begin
      step(1'b1, RU);
      case (k)
        12: begin want(K_PHASE, 8'd2, "full_rinse_phase"); want(K_REM, 8'd8, "full_rinse_rem"); want(K_ACT, ACT_INLET, "full_rinse_fill"); end
        13: begin want(K_REM, 8'd7, "full_rinse_rem7"); want(K_ACT, ACT_INLET, "full_rinse_fill7"); end
        15: begin want(K_REM, 8'd5, "full_rinse_rem5"); want(K_ACT, ACT_MOTOR, "full_rinse_motor"); end
        19: begin want(K_PHASE, 8'd2, "full_rinse_last"); want(K_REM, 8'd1, "full_rinse_rem1"); end
        20: begin want(K_PHASE, 8'd3, "full_spin_phase"); want(K_REM, 8'd6, "full_spin_rem"); want(K_ACT, ACT_SPIN, "full_spin_act"); end
        25: begin want(K_REM, 8'd1, "full_spin_rem1"); want(K_HAD, 8'd0, "full_not_done"); end
        26: begin want(K_PHASE, 8'd4, "full_done"); want(K_HAD, 8'd1, "full_had"); want(K_ACT, ACT_OFF, "full_done_act"); end
        default: ;
      endcase
    end
    step(1'b0, SD);

    // Asynchronous reset mid-rinse, then no resume.
    modeSel = 3'b010;
    step(1'b0, SE);
    step(1'b0, RU); want(K_PHASE, 8'd2, "ar_rinse"); want(K_REM, 8'd8, "ar_rem8");
    step(1'b1, RU);
    step(1'b1, RU); want(K_REM, 8'd6, "ar_rem6"); want(K_ACT, ACT_INLET, "ar_fill");
    step(1'b0, RU);
    @(posedge cp); #2 resetBtn = 1'b0;
    wantNow(K_PHASE, 8'd0, "async_phase");
    wantNow(K_REM, 8'd0, "async_remain");
    wantNow(K_ACT, ACT_OFF, "async_act");
    wantNow(K_HAD, 8'd0, "async_had");
    wantNow(K_INIT, 8'd5, "async_init");
    @(negedge cp); #1;
    state    = SD;
    resetBtn = 1'b1;
    step(1'b0, SD); want(K_PHASE, 8'd0, "post_reset_idle");
    step(1'b0, RU); want(K_PHASE, 8'd1, "no_resume_phase"); want(K_REM, 8'd12, "no_resume_rem");
    step(1'b0, SD);

    repeat (3) @(negedge cp);
    #1;
    nTotal++;
    if (sb.size() == 0) nPass++;
    else $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb.size());
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
